uart_rx_sampler: RTL and testbench

Parametrised oversampling bit sampler for the UART receive path. It takes the raw serial line plus the shared oversampling edge counter, and captures 3 or 5 samples centred on the bit midpoint for any prescale value. It then outputs a majority-voted bit with a one-cycle valid strobe, a noise flag and a configuration-error flag. It sits between the edge/bit counter and the RX FSM/deserializer, and adds an internal input synchronizer and programmable vote depth.

---
 rtl/uart_rx_sampler_if.sv | 25 ++
 rtl/uart_rx_sampler.sv | 138 +++++++++++++
 tb/tb_uart_rx_sampler.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sampler_if.sv
// Signal bundle between the edge counter / RX FSM and the oversampling bit sampler.
// master drives the line, enable and counter; slave is the sampler itself.
interface uart_rx_sampler_if #(
  parameter int unsigned SCALE_WIDTH = 6
) ();
  logic                   rx_in;
  logic                   samp_en;
  logic [SCALE_WIDTH-1:0] edge_cnt;
  logic [SCALE_WIDTH-1:0] prescaler;
  logic                   samp_mode;
  logic                   sampled_bit;
  logic                   bit_valid;
  logic                   noise_flag;
  logic                   cfg_err;

  modport master (
    output rx_in, samp_en, edge_cnt, prescaler, samp_mode,
    input  sampled_bit, bit_valid, noise_flag, cfg_err
  );

  modport slave (
    input  rx_in, samp_en, edge_cnt, prescaler, samp_mode,
    output sampled_bit, bit_valid, noise_flag, cfg_err
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// UART RX oversampling sampler: synchronizes rx_in, captures 3 or 5 samples
// centred on the bit midpoint and emits a majority vote with noise/config flags.
module uart_rx_sampler #(
  parameter int unsigned SCALE_WIDTH = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  uart_rx_sampler_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic                   rx_s;
  logic [4:0]             samp_q, samp_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [SCALE_WIDTH-1:0] lo_q, lo_d;
  logic                   mode_q, mode_d;
  logic                   bit_q, bit_d;
  logic                   valid_q, valid_d;
  logic                   noise_q, noise_d;
  logic                   cfg_q, cfg_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rx_s = bus.rx_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_q <= '1;
        end else begin
          sync_q[0] <= bus.rx_in;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign rx_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Config seen at a latch point (samp_en with edge_cnt == 0)
  logic                   latch;
  logic [SCALE_WIDTH-1:0] h_new;
  logic [SCALE_WIDTH-1:0] lo_new;
  logic                   illegal_new;
  assign latch       = bus.samp_en && (bus.edge_cnt == '0);
  assign h_new       = bus.samp_mode ? SCALE_WIDTH'(2) : SCALE_WIDTH'(1);
  assign lo_new      = (bus.prescaler >> 1) - h_new;
  assign illegal_new = bus.samp_mode ? (bus.prescaler < SCALE_WIDTH'(6))
                                     : (bus.prescaler < SCALE_WIDTH'(4));

  // Captures must hit consecutive window indices; a skipped index stalls the bit.
  logic [SCALE_WIDTH-1:0] target;
  logic [2:0]             n_cur;
  logic [4:0]             shifted;
  logic [4:0]             voted;
  assign target  = lo_q + SCALE_WIDTH'(cnt_q);
  assign n_cur   = mode_q ? 3'd5 : 3'd3;
  assign shifted = {samp_q[3:0], rx_s};
  assign voted   = shifted & (mode_q ? 5'b11111 : 5'b00111);

  logic [2:0] ones;

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    mode_d  = mode_q;
    bit_d   = bit_q;
    valid_d = 1'b0;
    noise_d = noise_q;
    cfg_d   = cfg_q;
    ones    = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      ones = ones + {2'b00, voted[i]};
    end

    if (!bus.samp_en) begin
      state_d = IDLE;
      samp_d  = '0;
      cnt_d   = '0;
    end else if (latch) begin
      cfg_d   = illegal_new;
      mode_d  = bus.samp_mode;
      lo_d    = lo_new;
      samp_d  = '0;
      cnt_d   = '0;
      state_d = illegal_new ? IDLE : COLLECT;
    end else if ((state_q == COLLECT) && (bus.edge_cnt == target)) begin
      samp_d = shifted;
      cnt_d  = cnt_q + 3'd1;
      if ((cnt_q + 3'd1) == n_cur) begin
        bit_d   = (ones >= (mode_q ? 3'd3 : 3'd2));
        noise_d = (ones != 3'd0) && (ones != n_cur);
        valid_d = 1'b1;
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      samp_q  <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      mode_q  <= 1'b0;
      bit_q   <= 1'b1;
      valid_q <= 1'b0;
      noise_q <= 1'b0;
      cfg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      mode_q  <= mode_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      noise_q <= noise_d;
      cfg_q   <= cfg_d;
    end
  end

  assign bus.sampled_bit = bit_q;
  assign bus.bit_valid   = valid_q;
  assign bus.noise_flag  = noise_q;
  assign bus.cfg_err     = cfg_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: two instances (no synchronizer and 2-stage) share
// one stimulus stream and are compared against a per-bit window/vote model.
module tb_uart_rx_sampler;
  localparam int unsigned SW   = 6;
  localparam int          MAXC = 8192;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_sampler_if #(.SCALE_WIDTH(SW)) bus0 ();
  uart_rx_sampler_if #(.SCALE_WIDTH(SW)) bus2 ();

  uart_rx_sampler #(.SCALE_WIDTH(SW), .SYNC_STAGES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  uart_rx_sampler #(.SCALE_WIDTH(SW), .SYNC_STAGES(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic sb_w[2], bv_w[2], nf_w[2], ce_w[2];
  assign sb_w[0] = bus0.sampled_bit;  assign sb_w[1] = bus2.sampled_bit;
  assign bv_w[0] = bus0.bit_valid;    assign bv_w[1] = bus2.bit_valid;
  assign nf_w[0] = bus0.noise_flag;   assign nf_w[1] = bus2.noise_flag;
  assign ce_w[0] = bus0.cfg_err;      assign ce_w[1] = bus2.cfg_err;

  int   vectors, errs, cyc, bit_start;
  logic rx_hist[MAXC];
  logic pat[64];
  int   vcnt[2], vcyc[2];
  logic vbit[2], vnoise[2];

  function automatic int dly_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  // Reference: vote over the 2h+1 line values seen at edges C-h..C+h of the bit
  task automatic model_expect(input int start, input int p, input logic m, input int dly,
                              output logic eb, output logic enz, output int last);
    int c, h, ones, idx;
    c = p / 2;
    h = m ? 2 : 1;
    ones = 0;
    for (int e = c - h; e <= c + h; e++) begin
      idx = start + e - dly;
      if (idx < 0 || rx_hist[idx] === 1'b1) ones++;
    end
    eb   = (ones >= h + 1);
    enz  = (ones > 0) && (ones < 2 * h + 1);
    last = start + c + h;
  endtask

  task automatic drive(input logic en, input int ec, input int p, input logic m, input logic r);
    bus0.samp_en = en; bus0.edge_cnt = SW'(ec); bus0.prescaler = SW'(p); bus0.samp_mode = m; bus0.rx_in = r;
    bus2.samp_en = en; bus2.edge_cnt = SW'(ec); bus2.prescaler = SW'(p); bus2.samp_mode = m; bus2.rx_in = r;
    rx_hist[cyc] = r;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (bv_w[k] === 1'b1) begin
        vcnt[k]++;
        vcyc[k]   = cyc;
        vbit[k]   = sb_w[k];
        vnoise[k] = nf_w[k];
      end
    end
    cyc++;
  endtask

  task automatic run_bit(input int p, input logic m, input int p_late, input logic m_late,
                         input int en_from, input int en_until);
    bit_start = cyc;
    vcnt[0] = 0;
    vcnt[1] = 0;
    for (int e = 0; e < p; e++) begin
      drive((e >= en_from) && (e < en_until), e, (e == 0) ? p : p_late, (e == 0) ? m : m_late, pat[e]);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) drive(1'b0, 0, 8, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      vectors += 4;
      if (sb_w[k] !== 1'b1) begin errs++; $display("FAIL reset_sampled_bit dut%0d got %b exp 1", k, sb_w[k]); end
      if (bv_w[k] !== 1'b0) begin errs++; $display("FAIL reset_bit_valid dut%0d got %b exp 0", k, bv_w[k]); end
      if (nf_w[k] !== 1'b0) begin errs++; $display("FAIL reset_noise dut%0d got %b exp 0", k, nf_w[k]); end
      if (ce_w[k] !== 1'b0) begin errs++; $display("FAIL reset_cfg_err dut%0d got %b exp 0", k, ce_w[k]); end
    end
    reset = 1'b0;
    repeat (3) drive(1'b0, 0, 8, 1'b0, 1'b1);
  endtask

  task automatic test_const_low;
    logic eb, enz;
    int   last;
    for (int e = 0; e < 64; e++) pat[e] = 1'b0;
    run_bit(8, 1'b0, 8, 1'b0, 0, 8);
    for (int k = 0; k < 2; k++) begin
      model_expect(bit_start, 8, 1'b0, dly_of(k), eb, enz, last);
      vectors++;
      if (vcnt[k] !== 1) begin errs++; $display("FAIL const_low_strobes dut%0d got %0d exp 1", k, vcnt[k]); end
      else begin
        vectors += 3;
        if (vcyc[k] !== last) begin errs++; $display("FAIL const_low_time dut%0d got %0d exp %0d", k, vcyc[k], last); end
        if (vbit[k] !== 1'b0) begin errs++; $display("FAIL const_low_bit dut%0d got %b exp 0", k, vbit[k]); end
        if (vnoise[k] !== 1'b0) begin errs++; $display("FAIL const_low_noise dut%0d got %b exp 0", k, vnoise[k]); end
      end
    end
  endtask

  task automatic test_glitch;
    logic eb, enz;
    int   last;
    for (int e = 0; e < 64; e++) pat[e] = (e != 7);
    run_bit(16, 1'b1, 16, 1'b1, 0, 16);
    for (int k = 0; k < 2; k++) begin
      model_expect(bit_start, 16, 1'b1, dly_of(k), eb, enz, last);
      vectors++;
      if (vcnt[k] !== 1) begin errs++; $display("FAIL glitch_strobes dut%0d got %0d exp 1", k, vcnt[k]); end
      else begin
        vectors += 3;
        if (vcyc[k] !== last) begin errs++; $display("FAIL glitch_time dut%0d got %0d exp %0d", k, vcyc[k], last); end
        if (vbit[k] !== 1'b1) begin errs++; $display("FAIL glitch_bit dut%0d got %b exp 1", k, vbit[k]); end
        if (vnoise[k] !== 1'b1) begin errs++; $display("FAIL glitch_noise dut%0d got %b exp 1", k, vnoise[k]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic eb, enz;
    int   last;
    logic bits[3];
    int   prev[2];
    bits[0] = 1'b0; bits[1] = 1'b1; bits[2] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int e = 0; e < 64; e++) pat[e] = bits[b];
      run_bit(10, 1'b0, 10, 1'b0, 0, 10);
      for (int k = 0; k < 2; k++) begin
        model_expect(bit_start, 10, 1'b0, dly_of(k), eb, enz, last);
        vectors++;
        if (vcnt[k] !== 1) begin errs++; $display("FAIL b2b_strobes bit%0d dut%0d got %0d exp 1", b, k, vcnt[k]); end
        else begin
          vectors += 3;
          if (b > 0 && vcyc[k] - prev[k] !== 10) begin errs++; $display("FAIL b2b_spacing bit%0d dut%0d got %0d exp 10", b, k, vcyc[k] - prev[k]); end
          else if (vcyc[k] !== last) begin errs++; $display("FAIL b2b_time bit%0d dut%0d got %0d exp %0d", b, k, vcyc[k], last); end
          if (vbit[k] !== eb) begin errs++; $display("FAIL b2b_bit bit%0d dut%0d got %b exp %b", b, k, vbit[k], eb); end
          if (vnoise[k] !== enz) begin errs++; $display("FAIL b2b_noise bit%0d dut%0d got %b exp %b", b, k, vnoise[k], enz); end
          prev[k] = vcyc[k];
        end
      end
    end
  endtask

  task automatic test_illegal;
    logic eb, enz;
    int   last;
    for (int e = 0; e < 64; e++) pat[e] = 1'b1;
    bit_start = cyc;
    vcnt[0] = 0; vcnt[1] = 0;
    drive(1'b1, 0, 5, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (ce_w[k] !== 1'b1) begin errs++; $display("FAIL illegal_cfg_err_set dut%0d got %b exp 1", k, ce_w[k]); end
    end
    for (int e = 1; e < 5; e++) drive(1'b1, e, 5, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      vectors += 2;
      if (vcnt[k] !== 0) begin errs++; $display("FAIL illegal_strobes dut%0d got %0d exp 0", k, vcnt[k]); end
      if (ce_w[k] !== 1'b1) begin errs++; $display("FAIL illegal_cfg_err_hold dut%0d got %b exp 1", k, ce_w[k]); end
    end
    for (int e = 0; e < 64; e++) pat[e] = e[0];
    run_bit(5, 1'b0, 5, 1'b0, 0, 5);
    for (int k = 0; k < 2; k++) begin
      model_expect(bit_start, 5, 1'b0, dly_of(k), eb, enz, last);
      vectors += 2;
      if (ce_w[k] !== 1'b0) begin errs++; $display("FAIL legal_cfg_err_clear dut%0d got %b exp 0", k, ce_w[k]); end
      if (vcnt[k] !== 1) begin errs++; $display("FAIL legal_strobes dut%0d got %0d exp 1", k, vcnt[k]); end
      else begin
        vectors += 2;
        if (vcyc[k] !== last) begin errs++; $display("FAIL legal_time dut%0d got %0d exp %0d", k, vcyc[k], last); end
        if (vbit[k] !== eb) begin errs++; $display("FAIL legal_bit dut%0d got %b exp %b", k, vbit[k], eb); end
      end
    end
  endtask

  task automatic test_abort;
    for (int e = 0; e < 64; e++) pat[e] = 1'b0;
    run_bit(8, 1'b0, 8, 1'b0, 0, 8);
    for (int k = 0; k < 2; k++) begin
      vectors += 2;
      if (vcnt[k] !== 1) begin errs++; $display("FAIL abort_pre_strobes dut%0d got %0d exp 1", k, vcnt[k]); end
      if (sb_w[k] !== 1'b0) begin errs++; $display("FAIL abort_pre_bit dut%0d got %b exp 0", k, sb_w[k]); end
    end
    for (int e = 0; e < 64; e++) pat[e] = 1'b1;
    // Drop at edge 4 (mid window), then at edge 5 (same edge as the final capture)
    for (int cut = 4; cut <= 5; cut++) begin
      run_bit(8, 1'b0, 8, 1'b0, 0, cut);
      for (int k = 0; k < 2; k++) begin
        vectors += 2;
        if (vcnt[k] !== 0) begin errs++; $display("FAIL abort_en%0d_strobes dut%0d got %0d exp 0", cut, k, vcnt[k]); end
        if (sb_w[k] !== 1'b0) begin errs++; $display("FAIL abort_en%0d_hold dut%0d got %b exp 0", cut, k, sb_w[k]); end
      end
    end
    for (int e = 0; e < 64; e++) pat[e] = 1'b0;
    run_bit(8, 1'b0, 8, 1'b0, 0, 8);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (vcnt[k] !== 1) begin errs++; $display("FAIL abort_recover_strobes dut%0d got %0d exp 1", k, vcnt[k]); end
    end
    vcnt[0] = 0; vcnt[1] = 0;
    for (int e = 0; e < 4; e++) drive(1'b1, e, 8, 1'b0, 1'b1);
    reset = 1'b1;
    drive(1'b1, 4, 8, 1'b0, 1'b1);
    reset = 1'b0;
    for (int e = 5; e < 8; e++) drive(1'b1, e, 8, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      vectors += 2;
      if (vcnt[k] !== 0) begin errs++; $display("FAIL reset_abort_strobes dut%0d got %0d exp 0", k, vcnt[k]); end
      if (sb_w[k] !== 1'b1) begin errs++; $display("FAIL reset_abort_bit dut%0d got %b exp 1", k, sb_w[k]); end
    end
  endtask

  task automatic test_midbit;
    logic eb, enz;
    int   last;
    for (int e = 0; e < 64; e++) pat[e] = 1'($urandom_range(0, 1));
    run_bit(8, 1'b0, 8, 1'b0, 3, 8);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (vcnt[k] !== 0) begin errs++; $display("FAIL midbit_en_strobes dut%0d got %0d exp 0", k, vcnt[k]); end
    end
    run_bit(8, 1'b0, 8, 1'b0, 0, 8);
    for (int k = 0; k < 2; k++) begin
      model_expect(bit_start, 8, 1'b0, dly_of(k), eb, enz, last);
      vectors++;
      if (vcnt[k] !== 1) begin errs++; $display("FAIL midbit_next_strobes dut%0d got %0d exp 1", k, vcnt[k]); end
      else begin
        vectors++;
        if (vbit[k] !== eb) begin errs++; $display("FAIL midbit_next_bit dut%0d got %b exp %b", k, vbit[k], eb); end
      end
    end
    // Mode switched to 5-sample and prescaler altered after the latch edge
    for (int e = 0; e < 64; e++) pat[e] = !(e == 6 || e == 7);
    for (int v = 0; v < 2; v++) begin
      run_bit(16, v[0], (v == 0) ? 16 : 7, ~v[0], 0, 16);
      for (int k = 0; k < 2; k++) begin
        model_expect(bit_start, 16, v[0], dly_of(k), eb, enz, last);
        vectors++;
        if (vcnt[k] !== 1) begin errs++; $display("FAIL cfgchg%0d_strobes dut%0d got %0d exp 1", v, k, vcnt[k]); end
        else begin
          vectors += 3;
          if (vcyc[k] !== last) begin errs++; $display("FAIL cfgchg%0d_time dut%0d got %0d exp %0d", v, k, vcyc[k], last); end
          if (vbit[k] !== eb) begin errs++; $display("FAIL cfgchg%0d_bit dut%0d got %b exp %b", v, k, vbit[k], eb); end
          if (vnoise[k] !== enz) begin errs++; $display("FAIL cfgchg%0d_noise dut%0d got %b exp %b", v, k, vnoise[k], enz); end
        end
      end
    end
  endtask

  task automatic test_random;
    logic eb, enz, m, base, legal;
    int   last, p;
    for (int it = 0; it < 40; it++) begin
      m    = 1'($urandom_range(0, 1));
      p    = $urandom_range(2, 40);
      base = 1'($urandom_range(0, 1));
      for (int e = 0; e < 64; e++) pat[e] = ($urandom_range(0, 3) == 0) ? ~base : base;
      legal = m ? (p >= 6) : (p >= 4);
      run_bit(p, m, p, m, 0, p);
      for (int k = 0; k < 2; k++) begin
        vectors += 2;
        if (ce_w[k] !== ~legal) begin errs++; $display("FAIL rand%0d_cfg_err dut%0d got %b exp %b (p=%0d m=%b)", it, k, ce_w[k], ~legal, p, m); end
        if (vcnt[k] !== (legal ? 1 : 0)) begin errs++; $display("FAIL rand%0d_strobes dut%0d got %0d exp %0d (p=%0d m=%b)", it, k, vcnt[k], legal ? 1 : 0, p, m); end
        else if (legal) begin
          model_expect(bit_start, p, m, dly_of(k), eb, enz, last);
          vectors += 3;
          if (vcyc[k] !== last) begin errs++; $display("FAIL rand%0d_time dut%0d got %0d exp %0d", it, k, vcyc[k], last); end
          if (vbit[k] !== eb) begin errs++; $display("FAIL rand%0d_bit dut%0d got %b exp %b", it, k, vbit[k], eb); end
          if (vnoise[k] !== enz) begin errs++; $display("FAIL rand%0d_noise dut%0d got %b exp %b", it, k, vnoise[k], enz); end
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    errs    = 0;
    cyc     = 0;
    for (int i = 0; i < MAXC; i++) rx_hist[i] = 1'b1;
    bus0.samp_en = 1'b0; bus0.edge_cnt = '0; bus0.prescaler = SW'(8); bus0.samp_mode = 1'b0; bus0.rx_in = 1'b1;
    bus2.samp_en = 1'b0; bus2.edge_cnt = '0; bus2.prescaler = SW'(8); bus2.samp_mode = 1'b0; bus2.rx_in = 1'b1;
    reset = 1'b1;
    test_reset;
    test_const_low;
    test_glitch;
    test_back_to_back;
    test_illegal;
    test_abort;
    test_midbit;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
